// File: rtl/vdp_port_ifce.sv
// vdp99 CPU-port front end: two-byte control-port decode, register file,
// VRAM address pointer, data-port read-ahead/write sequencing over a
// req/ack handshake, and status/interrupt flags.
module vdp_port_ifce #(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_WIDTH  = 14,
    parameter int ADDR_HI_REG = 14
) (
    input  logic                    pxclk,
    input  logic                    reset,
    input  logic                    wr0_tick,
    input  logic                    rd0_tick,
    input  logic                    wr1_tick,
    input  logic                    rd1_tick,
    input  logic [7:0]              din,
    output logic [7:0]              data_dout,
    output logic [7:0]              status_dout,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic                    irq,
    input  logic                    frame_tick,
    input  logic                    fifth_tick,
    input  logic [4:0]              fifth_num_in,
    input  logic                    coinc_tick,
    output logic                    vram_req,
    output logic                    vram_we,
    output logic [ADDR_WIDTH-1:0]   vram_addr,
    output logic [7:0]              vram_wdata,
    input  logic                    vram_ack,
    input  logic [7:0]              vram_rdata,
    output logic                    overrun
);
    localparam int RIDX_W = $clog2(NUM_REGS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic [NUM_REGS-1:0][7:0] regs;
    logic [7:0]               byte1;
    logic                     latch;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [ADDR_WIDTH-1:0]    set_addr;
    logic [7:0]               rbuf;
    logic [1:0]               state;
    logic                     skip_inc;   // pointer was rewritten mid-op; ack must not bump it
    logic                     pf_pend;    // prefetch requested while busy
    logic                     int_flag, fifth_flag, coinc_flag;
    logic [4:0]               fifth_num;

    logic ctl2, reg_wr, addr_wr, pf_req, idle;
    assign ctl2    = wr1_tick & latch;
    assign reg_wr  = ctl2 & din[7];
    assign addr_wr = ctl2 & ~din[7];
    assign pf_req  = addr_wr & ~din[6];
    assign idle    = (state == S_IDLE);

    // New pointer value from the second control byte; upper bits come
    // from the designated register when the address space exceeds 16K.
    generate
        if (ADDR_WIDTH > 14) begin : g_hi
            logic [7:0] hi_reg;
            assign hi_reg   = regs[ADDR_HI_REG];
            assign set_addr = {hi_reg[ADDR_WIDTH-15:0], din[5:0], byte1};
        end else begin : g_lo
            assign set_addr = {din[5:0], byte1};
        end
    endgenerate

    // Control-port byte latch and register writes.
    always_ff @(posedge pxclk) begin
        if (reset) begin
            regs  <= '0;
            byte1 <= 8'h00;
            latch <= 1'b0;
        end else begin
            if (wr1_tick) begin
                if (!latch) begin
                    byte1 <= din;
                    latch <= 1'b1;
                end else begin
                    latch <= 1'b0;
                end
            end
            if (rd1_tick || wr0_tick || rd0_tick)
                latch <= 1'b0;
            if (reg_wr)
                regs[din[RIDX_W-1:0]] <= byte1;
        end
    end

    // VRAM access sequencer and address pointer.
    always_ff @(posedge pxclk) begin
        if (reset) begin
            state      <= S_IDLE;
            addr       <= '0;
            rbuf       <= 8'h00;
            vram_addr  <= '0;
            vram_wdata <= 8'h00;
            skip_inc   <= 1'b0;
            pf_pend    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= (wr0_tick | rd0_tick) & ~idle;
            case (state)
                S_IDLE: begin
                    if (wr0_tick) begin
                        state      <= S_WR;
                        vram_addr  <= addr;
                        vram_wdata <= din;
                        rbuf       <= din;
                    end else if (rd0_tick) begin
                        state     <= S_RD;
                        vram_addr <= addr;
                        pf_pend   <= 1'b0;
                    end else if (pf_req) begin
                        state     <= S_RD;
                        vram_addr <= set_addr;
                    end else if (pf_pend && !addr_wr) begin
                        state     <= S_RD;
                        vram_addr <= addr;
                        pf_pend   <= 1'b0;
                    end
                end
                default: begin
                    if (vram_ack) begin
                        state    <= S_IDLE;
                        skip_inc <= 1'b0;
                        if (state == S_RD)
                            rbuf <= vram_rdata;
                        if (!skip_inc && !addr_wr)
                            addr <= addr + ADDR_WIDTH'(1);
                    end
                end
            endcase
            // A pointer rewrite always wins; if an op is (or is becoming)
            // in flight, its completion must leave the new pointer alone
            // and any requested prefetch waits for the return to idle.
            if (addr_wr) begin
                addr <= set_addr;
                if (!idle)
                    skip_inc <= ~vram_ack;
                else if (wr0_tick || rd0_tick)
                    skip_inc <= 1'b1;
                if (!idle || wr0_tick || rd0_tick)
                    pf_pend <= ~din[6];
                else
                    pf_pend <= 1'b0;
            end
        end
    end

    // Status flags: a set tick beats a coincident status-read clear.
    always_ff @(posedge pxclk) begin
        if (reset) begin
            int_flag   <= 1'b0;
            fifth_flag <= 1'b0;
            coinc_flag <= 1'b0;
            fifth_num  <= 5'd0;
        end else begin
            if (frame_tick)    int_flag <= 1'b1;
            else if (rd1_tick) int_flag <= 1'b0;
            if (fifth_tick) begin
                fifth_flag <= 1'b1;
                if (!fifth_flag) fifth_num <= fifth_num_in;
            end else if (rd1_tick) begin
                fifth_flag <= 1'b0;
            end
            if (coinc_tick)    coinc_flag <= 1'b1;
            else if (rd1_tick) coinc_flag <= 1'b0;
        end
    end

    assign vram_req    = ~idle;
    assign vram_we     = (state == S_WR);
    assign data_dout   = rbuf;
    assign status_dout = {int_flag, fifth_flag, coinc_flag, fifth_num};
    assign regs_flat   = regs;
    assign irq         = int_flag & regs[1][5];
endmodule

// File: tb/tb_vdp_port_ifce.sv
// Self-checking bench for vdp_port_ifce: expected VRAM requests are queued
// when the CPU tick is driven and compared when the DUT raises vram_req.
module tb_vdp_port_ifce;
    logic        pxclk = 1'b0;
    logic        reset;
    logic        wr0_tick, rd0_tick, wr1_tick, rd1_tick;
    logic [7:0]  din;
    logic [7:0]  data_dout, status_dout;
    logic [63:0] regs_flat;
    logic        irq;
    logic        frame_tick, fifth_tick, coinc_tick;
    logic [4:0]  fifth_num_in;
    logic        vram_req, vram_we, vram_ack, overrun;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  wdata;
    } req_t;

    req_t        sbq[$];
    logic [63:0] exp_regs;
    int          n_vec = 0;
    int          n_err = 0;

    vdp_port_ifce dut (
        .pxclk(pxclk), .reset(reset),
        .wr0_tick(wr0_tick), .rd0_tick(rd0_tick),
        .wr1_tick(wr1_tick), .rd1_tick(rd1_tick),
        .din(din), .data_dout(data_dout), .status_dout(status_dout),
        .regs_flat(regs_flat), .irq(irq),
        .frame_tick(frame_tick), .fifth_tick(fifth_tick),
        .fifth_num_in(fifth_num_in), .coinc_tick(coinc_tick),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .overrun(overrun)
    );

    always #20 pxclk = ~pxclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge pxclk);
        #1;
    endtask

    task automatic wr1(input logic [7:0] d);
        din = d; wr1_tick = 1'b1; step(); wr1_tick = 1'b0;
    endtask

    task automatic wr0(input logic [7:0] d);
        din = d; wr0_tick = 1'b1; step(); wr0_tick = 1'b0;
    endtask

    task automatic rd0();
        rd0_tick = 1'b1; step(); rd0_tick = 1'b0;
    endtask

    task automatic rd1();
        rd1_tick = 1'b1; step(); rd1_tick = 1'b0;
    endtask

    task automatic wait_req();
        req_t e;
        int   n = 0;
        while (!vram_req && n < 20) begin
            step();
            n++;
        end
        if (!vram_req) chk("req_timeout", vram_req, 1);
        else if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
        else begin
            e = sbq.pop_front();
            chk("req_we", vram_we, e.we);
            chk("req_addr", vram_addr, e.addr);
            if (e.we) chk("req_wdata", vram_wdata, e.wdata);
        end
    endtask

    task automatic ack(input int dly, input logic [7:0] d);
        repeat (dly) step();
        vram_rdata = d; vram_ack = 1'b1;
        step();
        vram_ack = 1'b0;
        chk("req_drop", vram_req, 0);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        {wr0_tick, rd0_tick, wr1_tick, rd1_tick} = '0;
        {frame_tick, fifth_tick, coinc_tick, vram_ack} = '0;
        din = 8'h00; fifth_num_in = 5'd0; vram_rdata = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_regs", regs_flat, 0);
        chk("rst_status", status_dout, 0);
        chk("rst_dout", data_dout, 0);
        chk("rst_req", vram_req, 0);
        chk("rst_irq", irq, 0);
        chk("rst_ovr", overrun, 0);

        // register write to the top index
        wr1(8'h5A); wr1(8'h87);
        exp_regs = 64'h5A00_0000_0000_0000;
        chk("reg7", regs_flat, exp_regs);

        // write at 0x1234, then read-at-pointer shows increment
        wr1(8'h34); wr1(8'h52);
        sbq.push_back('{1'b1, 14'h1234, 8'hAA});
        wr0(8'hAA);
        chk("wr_dout", data_dout, 8'hAA);
        wait_req();
        ack(3, 8'h00);
        sbq.push_back('{1'b0, 14'h1235, 8'h00});
        rd0();
        chk("rd_early_dout", data_dout, 8'hAA);
        wait_req();
        ack(0, 8'h5C);
        chk("rd_dout", data_dout, 8'h5C);

        // prefetch at top of memory, pointer wraps
        wr1(8'hFF);
        sbq.push_back('{1'b0, 14'h3FFF, 8'h00});
        wr1(8'h3F);
        wait_req();
        ack(1, 8'h11);
        chk("pf_dout", data_dout, 8'h11);
        sbq.push_back('{1'b0, 14'h0000, 8'h00});
        rd0();
        wait_req();
        ack(0, 8'h22);
        chk("wrap_dout", data_dout, 8'h22);

        // data-port tick while busy is dropped
        wr1(8'h00); wr1(8'h50);
        sbq.push_back('{1'b1, 14'h1000, 8'h33});
        wr0(8'h33);
        wait_req();
        wr0(8'h44);
        chk("ovr_pulse", overrun, 1);
        step();
        chk("ovr_clear", overrun, 0);
        chk("ovr_wdata", vram_wdata, 8'h33);
        ack(1, 8'h00);
        repeat (4) step();
        chk("ovr_single_req", vram_req, 0);
        chk("ovr_dout", data_dout, 8'h33);

        // interrupt and status flags
        wr1(8'h20); wr1(8'h81);
        exp_regs[15:8] = 8'h20;
        chk("reg1", regs_flat, exp_regs);
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        chk("irq_set", irq, 1);
        chk("int_flag", status_dout[7], 1);
        frame_tick = 1'b1; rd1_tick = 1'b1; step();
        frame_tick = 1'b0; rd1_tick = 1'b0;
        chk("irq_set_wins", irq, 1);
        rd1();
        chk("irq_clr", irq, 0);
        fifth_num_in = 5'h13; fifth_tick = 1'b1; step(); fifth_tick = 1'b0;
        chk("fifth_set", status_dout, 8'h53);
        fifth_num_in = 5'h05; fifth_tick = 1'b1; step(); fifth_tick = 1'b0;
        chk("fifth_hold", status_dout, 8'h53);
        coinc_tick = 1'b1; step(); coinc_tick = 1'b0;
        chk("coinc_set", status_dout, 8'h73);
        rd1();
        chk("flags_clr", status_dout[7:5], 0);

        // status read resets the byte latch
        wr1(8'h12); rd1(); wr1(8'h40);
        chk("latch_no_reg", regs_flat, exp_regs);
        wr1(8'h83);
        exp_regs[31:24] = 8'h40;
        chk("latch_first_byte", regs_flat, exp_regs);
        sbq.push_back('{1'b0, 14'h1001, 8'h00});
        rd0();
        wait_req();
        ack(0, 8'h66);
        chk("latch_addr_kept", data_dout, 8'h66);

        // pointer rewrite during a write: no increment, deferred prefetch
        sbq.push_back('{1'b1, 14'h1002, 8'h77});
        wr0(8'h77);
        wait_req();
        wr1(8'h00); wr1(8'h20);
        chk("busy_addr_hold", vram_addr, 14'h1002);
        ack(2, 8'h00);
        sbq.push_back('{1'b0, 14'h2000, 8'h00});
        wait_req();
        ack(1, 8'h99);
        chk("defer_pf_dout", data_dout, 8'h99);
        sbq.push_back('{1'b0, 14'h2001, 8'h00});
        rd0();
        wait_req();
        ack(0, 8'h3C);
        chk("after_defer_dout", data_dout, 8'h3C);
        chk("sb_left", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
